// File: rtl/any1_tlb_walker.sv
// any1_tlb_walker: single-level hardware page-table walker for the ANY1 TLB.
// On a TLB miss it fetches one 64-bit PTE over a Wishbone-style master port,
// checks its valid bit and writes a TLB entry into a round-robin way. Invalid
// PTEs produce a page-fault pulse.
//
// Optional feature: define ANY1_TLB_WALKER_TIMEOUT_EN to abort a bus read
// that has not been acknowledged within TMO cycles (berr_o pulse). Without
// the macro the walker waits for ack_i indefinitely and berr_o is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for miss_i; captures address/asid and bus address
// S_REQ   | bus read of the PTE in flight (cyc_o/stb_o high)
// S_CHECK | PTE registered; valid -> write, invalid -> fault pulse
// S_WRITE | wrtlb_o high for exactly one cycle
// S_DONE  | done_o high for one cycle, then back to idle
//
// TLB entry layout (tlbdat_o):
//   [63:56] asid   [55] global   [54:53] dirty/accessed (cleared)
//   [52] 0   [51:48] acr   [47:40] 0   [AWID+7:32] vaddr tag adr[AWID-1:24]
//   [31:18] 0   [17:0] ppn
module any1_tlb_walker #(
  parameter int AWID = 32,
  parameter int TMO  = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            miss_i,
  input  logic [AWID-1:0] miss_adr_i,
  input  logic [7:0]      asid_i,
  input  logic [AWID-1:0] ptbr_i,
  output logic            busy_o,
  output logic            cyc_o,
  output logic            stb_o,
  input  logic            ack_i,
  output logic [AWID-1:0] adr_o,
  input  logic [63:0]     dat_i,
  output logic            wrtlb_o,
  output logic [11:0]     tlbadr_o,
  output logic [63:0]     tlbdat_o,
  output logic            done_o,
  output logic            fault_o,
  output logic            berr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [AWID-15:0]  vpn_q;
  logic [7:0]        asid_q;
  logic              pte_v_q;
  logic              pte_g_q;
  logic [3:0]        pte_acr_q;
  logic [17:0]       pte_ppn_q;
  logic [1:0]        way_q;
  logic              cyc_q;
  logic              wrtlb_q;
  logic              done_q;
  logic              fault_q;
  logic [AWID-1:0]   adr_q;
  logic [11:0]       tlbadr_q;
  logic [63:0]       tlbdat_q;

  logic [AWID-1:0]   adr_d;
  logic [11:0]       tlbadr_d;
  logic [63:0]       tlbdat_d;

`ifdef ANY1_TLB_WALKER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  logic [7:0]        tmo_cnt_q;
  logic              berr_q;
`endif

  // PTE address: table base plus 8-byte-scaled vpn, wrapping at AWID bits
  always_comb begin
    adr_d = ptbr_i + AWID'({miss_adr_i[AWID-1:14], 3'b000});
  end

  // TLB entry and slot assembled from the captured walk context
  always_comb begin
    tlbadr_d                = {way_q, vpn_q[9:0]};
    tlbdat_d                = '0;
    tlbdat_d[63:56]         = asid_q;
    tlbdat_d[55]            = pte_g_q;
    tlbdat_d[51:48]         = pte_acr_q;
    tlbdat_d[AWID+7:32]     = vpn_q[AWID-15:10];
    tlbdat_d[17:0]          = pte_ppn_q;
  end

  // Walk sequencer with registered bus and strobe outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      vpn_q     <= '0;
      asid_q    <= '0;
      pte_v_q   <= 1'b0;
      pte_g_q   <= 1'b0;
      pte_acr_q <= '0;
      pte_ppn_q <= '0;
      way_q     <= '0;
      cyc_q     <= 1'b0;
      wrtlb_q   <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      adr_q     <= '0;
      tlbadr_q  <= '0;
      tlbdat_q  <= '0;
`ifdef ANY1_TLB_WALKER_TIMEOUT_EN
      tmo_cnt_q <= '0;
      berr_q    <= 1'b0;
`endif
    end else begin
      wrtlb_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
`ifdef ANY1_TLB_WALKER_TIMEOUT_EN
      berr_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (miss_i) begin
            vpn_q   <= miss_adr_i[AWID-1:14];
            asid_q  <= asid_i;
            adr_q   <= adr_d;
            cyc_q   <= 1'b1;
`ifdef ANY1_TLB_WALKER_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_i) begin
            pte_v_q   <= dat_i[63];
            pte_g_q   <= dat_i[55];
            pte_acr_q <= dat_i[51:48];
            pte_ppn_q <= dat_i[17:0];
            cyc_q     <= 1'b0;
            state_q   <= S_CHECK;
          end
`ifdef ANY1_TLB_WALKER_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            cyc_q   <= 1'b0;
            berr_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        S_CHECK: begin
          if (pte_v_q) begin
            wrtlb_q  <= 1'b1;
            tlbadr_q <= tlbadr_d;
            tlbdat_q <= tlbdat_d;
            state_q  <= S_WRITE;
          end else begin
            fault_q  <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_WRITE: begin
          way_q   <= way_q + 2'd1;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign cyc_o    = cyc_q;
  assign stb_o    = cyc_q;
  assign adr_o    = adr_q;
  assign wrtlb_o  = wrtlb_q;
  assign tlbadr_o = tlbadr_q;
  assign tlbdat_o = tlbdat_q;
  assign done_o   = done_q;
  assign fault_o  = fault_q;

`ifdef ANY1_TLB_WALKER_TIMEOUT_EN
  assign berr_o = berr_q;
`else
  assign berr_o = 1'b0;
  // TMO only matters when the bus timeout is built in
  logic unused_tmo;
  assign unused_tmo = ^TMO;
`endif

  // PTE fields and page-offset bits the walker deliberately ignores
  logic unused_bits;
  assign unused_bits = ^{miss_adr_i[13:0], dat_i[62:56], dat_i[54:52], dat_i[47:18]};

endmodule

// File: tb/tb_any1_tlb_walker.sv
module tb_any1_tlb_walker;
  localparam int AWID = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            miss_i;
  logic [AWID-1:0] miss_adr_i;
  logic [7:0]      asid_i;
  logic [AWID-1:0] ptbr_i;
  logic            busy_o, cyc_o, stb_o, ack_i;
  logic [AWID-1:0] adr_o;
  logic [63:0]     dat_i;
  logic            wrtlb_o;
  logic [11:0]     tlbadr_o;
  logic [63:0]     tlbdat_o;
  logic            done_o, fault_o, berr_o;

  any1_tlb_walker #(.AWID(AWID), .TMO(255)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .miss_i(miss_i), .miss_adr_i(miss_adr_i),
    .asid_i(asid_i), .ptbr_i(ptbr_i), .busy_o(busy_o), .cyc_o(cyc_o),
    .stb_o(stb_o), .ack_i(ack_i), .adr_o(adr_o), .dat_i(dat_i),
    .wrtlb_o(wrtlb_o), .tlbadr_o(tlbadr_o), .tlbdat_o(tlbdat_o),
    .done_o(done_o), .fault_o(fault_o), .berr_o(berr_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int n_wr = 0, n_done = 0, n_fault = 0, n_berr = 0, n_excl = 0;
  logic [11:0] wr_adr = '0;
  logic [63:0] wr_dat = '0;

  // pulse monitor, sampled mid-cycle
  always @(negedge clk_i) begin
    if (wrtlb_o) begin
      n_wr++;
      wr_adr = tlbadr_o;
      wr_dat = tlbdat_o;
    end
    if (done_o)  n_done++;
    if (fault_o) n_fault++;
    if (berr_o)  n_berr++;
    if ((32'(wrtlb_o) + 32'(done_o) + 32'(fault_o) + 32'(berr_o)) > 1) n_excl++;
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one complete walk; dup re-pulses miss_i with another address during REQ
  task automatic walk(input logic [31:0] va, input logic [7:0] as, input logic [63:0] pte,
                      input int dly, input bit dup, input logic [31:0] exp_adr);
    int k;
    miss_i = 1'b1; miss_adr_i = va; asid_i = as;
    tick();
    miss_i = 1'b0;
    chk("req_cyc", {62'd0, cyc_o, stb_o}, 64'h3);
    chk("req_adr", 64'(adr_o), 64'(exp_adr));
    for (int i = 0; i < dly; i++) begin
      if (dup && i == 0) begin miss_i = 1'b1; miss_adr_i = 32'hDEAD_C000; asid_i = 8'h77; end
      tick();
      miss_i = 1'b0;
    end
    ack_i = 1'b1; dat_i = pte;
    tick();
    ack_i = 1'b0; dat_i = '0;
    k = 0;
    while (!done_o && !fault_o && k < 20) begin tick(); k++; end
    if (k >= 20) chk("walk_bound", 64'd1, 64'd0);
    tick();
  endtask

  logic [31:0] w_ptbr [5] = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFF8, 32'h0000_1000, 32'h0001_0000};
  logic [31:0] w_va   [5] = '{32'h0123_4000, 32'hFFFF_C000, 32'h0000_4000, 32'h8000_0000, 32'h0123_7FFF};
  logic [7:0]  w_as   [5] = '{8'h05, 8'hA5, 8'h00, 8'h3C, 8'hFF};
  logic [63:0] w_pte  [5] = '{64'h8000_0000_0003_0ABC, 64'hFF8F_1234_FFFC_0001,
                             64'h8000_0000_0003_FFFF, 64'h8001_0000_0000_0000,
                             64'h8000_0000_0000_0000};
  int          w_dly  [5] = '{0, 1, 3, 0, 2};
  logic [31:0] w_adr  [5] = '{32'h0001_2468, 32'h0020_FFF8, 32'h0000_0000, 32'h0010_1000, 32'h0001_2468};
  logic [11:0] w_tadr [5] = '{12'h08D, 12'h7FF, 12'h801, 12'hC00, 12'h08D};
  logic [63:0] w_tdat [5] = '{64'h0500_0001_0003_0ABC, 64'hA58F_00FF_0000_0001,
                             64'h0000_0000_0003_FFFF, 64'h3C01_0080_0000_0000,
                             64'hFF00_0001_0000_0000};

  initial begin
    int wr0, f0, d0, b0, k;
    rst_ni = 1'b0; miss_i = 1'b0; miss_adr_i = '0; asid_i = '0;
    ptbr_i = 32'h0001_0000; ack_i = 1'b0; dat_i = '0;
    tick(); tick();
    chk("rst_busy",   64'(busy_o), 64'd0);
    chk("rst_cyc",    {62'd0, cyc_o, stb_o}, 64'd0);
    chk("rst_adr",    64'(adr_o), 64'd0);
    chk("rst_tlbadr", 64'(tlbadr_o), 64'd0);
    chk("rst_tlbdat", tlbdat_o, 64'd0);
    chk("rst_pulses", {60'd0, wrtlb_o, done_o, fault_o, berr_o}, 64'd0);

    // directed reference walk; miss presented together with reset release
    rst_ni = 1'b1;
    miss_i = 1'b1; miss_adr_i = 32'h0123_4000; asid_i = 8'h05;
    tick();
    miss_i = 1'b0;
    chk("t1_busy", 64'(busy_o), 64'd1);
    chk("t1_cyc",  {62'd0, cyc_o, stb_o}, 64'h3);
    chk("t1_adr",  64'(adr_o), 64'h0001_2468);
    tick();
    chk("t1_wait_cyc", 64'(cyc_o), 64'd1);
    tick();
    ack_i = 1'b1; dat_i = 64'h8000_0000_0003_0ABC;
    tick();
    ack_i = 1'b0; dat_i = '0;
    chk("t1_check_cyc", {62'd0, cyc_o, wrtlb_o}, 64'd0);
    tick();
    chk("t1_wrtlb",  64'(wrtlb_o), 64'd1);
    chk("t1_tlbadr", 64'(tlbadr_o), 64'h08D);
    chk("t1_tlbdat", tlbdat_o, 64'h0500_0001_0003_0ABC);
    tick();
    chk("t1_done", {62'd0, done_o, wrtlb_o}, 64'h2);
    tick();
    chk("t1_idle", {62'd0, busy_o, done_o}, 64'd0);
    chk("t1_counts", {32'(n_wr), 32'(n_done)}, {32'd1, 32'd1});
    chk("t1_hold_dat", tlbdat_o, 64'h0500_0001_0003_0ABC);

    // invalid PTE -> page fault, no write, held TLB outputs
    wr0 = n_wr; f0 = n_fault;
    walk(32'h0123_4000, 8'h05, 64'h0, 2, 1'b0, 32'h0001_2468);
    chk("t2_fault_cnt", 64'(n_fault - f0), 64'd1);
    chk("t2_no_write",  64'(n_wr - wr0), 64'd0);
    chk("t2_busy",      64'(busy_o), 64'd0);
    chk("t2_hold_adr",  64'(tlbadr_o), 64'h08D);

    // five walks from reset: round-robin ways 0,1,2,3,0 plus entry formatting
    rst_ni = 1'b0; #1; rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ptbr_i = w_ptbr[i];
      wr0 = n_wr;
      walk(w_va[i], w_as[i], w_pte[i], w_dly[i], 1'b0, w_adr[i]);
      chk($sformatf("t3_wr_cnt%0d", i), 64'(n_wr - wr0), 64'd1);
      chk($sformatf("t3_way%0d", i), 64'(wr_adr[11:10]), 64'(i % 4));
      chk($sformatf("t3_tlbadr%0d", i), 64'(wr_adr), 64'(w_tadr[i]));
      chk($sformatf("t3_tlbdat%0d", i), wr_dat, w_tdat[i]);
    end

    // second miss during REQ is ignored (way is now 1)
    ptbr_i = 32'h0001_0000;
    wr0 = n_wr;
    walk(32'h0123_4000, 8'h05, 64'h8000_0000_0003_0ABC, 2, 1'b1, 32'h0001_2468);
    chk("t4_one_write", 64'(n_wr - wr0), 64'd1);
    chk("t4_tlbadr",    64'(wr_adr), 64'h48D);
    chk("t4_tlbdat",    wr_dat, 64'h0500_0001_0003_0ABC);

    // ack never arrives
    wr0 = n_wr; b0 = n_berr;
    miss_i = 1'b1; miss_adr_i = 32'h0123_4000; asid_i = 8'h09;
    tick();
    miss_i = 1'b0;
    k = 0;
`ifdef ANY1_TLB_WALKER_TIMEOUT_EN
    while (cyc_o && k < 1100) begin k++; tick(); end
    chk("t5_req_cycles", 64'(k), 64'd255);
    tick();
    chk("t5_berr_cnt",   64'(n_berr - b0), 64'd1);
    chk("t5_busy",       64'(busy_o), 64'd0);
`else
    for (int i = 0; i < 1000; i++) begin
      if (cyc_o) k++;
      tick();
    end
    chk("t5_cyc_held",   64'(k), 64'd1000);
    chk("t5_berr_cnt",   64'(n_berr - b0), 64'd0);
`endif
    chk("t5_no_write",   64'(n_wr - wr0), 64'd0);

    // reset between edges while in REQ
    miss_i = 1'b1; miss_adr_i = 32'h0123_4000;
    tick();
    miss_i = 1'b0;
    tick();
    chk("t6_pre_cyc", 64'(cyc_o), 64'd1);
    wr0 = n_wr; d0 = n_done;
    rst_ni = 1'b0;
    #1;
    chk("t6_async_cyc",  {62'd0, cyc_o, busy_o}, 64'd0);
    #1;
    rst_ni = 1'b1;
    ack_i = 1'b1; dat_i = 64'h8000_0000_0003_0ABC;
    tick(); tick();
    ack_i = 1'b0; dat_i = '0;
    tick(); tick(); tick();
    chk("t6_no_write",   {32'(n_wr - wr0), 32'(n_done - d0)}, 64'd0);
    chk("t6_idle",       64'(busy_o), 64'd0);

    chk("excl_pulses", 64'(n_excl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
